// File: rtl/pc_trace_monitor_pkg.sv
// Shared types for the PC trace monitor: run-state encoding, trace entry layout, pointer width.
package trace_pkg;

    localparam int unsigned DEF_PC_W  = 32;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned PTR_W     = $clog2(DEF_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Entry layout at default widths; the FIFO stores {cycle, pc} in this order.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] cycle;
        logic [DEF_PC_W-1:0]  pc;
    } trace_entry_t;

endpackage

// File: rtl/pc_trace_monitor_if.sv
// Valid/ready trace drain port of the PC trace monitor.
interface trace_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             trace_valid;
    logic             trace_ready;
    logic [CNT_W-1:0] trace_cycle;
    logic [PC_W-1:0]  trace_pc;

    modport master (output trace_valid, trace_cycle, trace_pc, input trace_ready);
    modport slave  (input trace_valid, trace_cycle, trace_pc, output trace_ready);
endinterface

// File: rtl/pc_trace_monitor_fifo.sv
// Synchronous FIFO with flush, simultaneous push/pop and a registered head (valid + data).
module trace_fifo #(
    parameter int unsigned W     = 48,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_dout,
    output logic         o_drop_c
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr, r_rd;
    logic         r_valid;
    logic [W-1:0] r_head;

    logic        w_pop, w_full, w_push_ok;
    logic [AW:0] w_wr_base, w_rd_next, w_wr_next;

    // Flush rebases both pointers to zero so a push on the same edge lands in slot 0.
    always_comb begin
        w_pop     = r_valid && i_ready;
        w_full    = (r_wr - r_rd) == (AW+1)'(DEPTH);
        w_wr_base = i_flush ? '0 : r_wr;
        w_rd_next = i_flush ? '0 : (w_pop ? r_rd + (AW+1)'(1) : r_rd);
        w_push_ok = i_push && (i_flush || !w_full || w_pop);
        w_wr_next = w_wr_base + (AW+1)'(w_push_ok);
    end

    assign o_drop_c = i_push && !w_push_ok;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[w_wr_base[AW-1:0]] <= i_din;
    end

    // Head bypasses the array when the entry being written becomes the new head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else begin
            r_wr    <= w_wr_next;
            r_rd    <= w_rd_next;
            r_valid <= (w_wr_next != w_rd_next);
            r_head  <= (w_push_ok && (w_wr_base == w_rd_next)) ? i_din
                                                              : r_mem[w_rd_next[AW-1:0]];
        end
    end

    assign o_valid = r_valid;
    assign o_dout  = r_head;
endmodule

// File: rtl/pc_trace_monitor.sv
// Run monitor: cycle counter, PC-change trace FIFO, halt/timeout detection.
// Optional register snapshot at run end when SNAPSHOT_EN is defined.
module pc_trace_monitor
    import trace_pkg::*;
#(
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned NUM_WATCH   = 6,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned MAX_CYCLES  = 20,
    parameter int unsigned STALL_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_WATCH*32-1:0] watch,
    trace_if.master                trace,
    output logic [CNT_W-1:0]       cycles,
    output logic                   running,
    output logic                   halted,
    output logic                   timeout,
    output logic                   overflow
`ifdef SNAPSHOT_EN
    ,output logic [NUM_WATCH*32-1:0] snap_data
`endif
);
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
    localparam int unsigned EW = CNT_W + PC_W;

    state_t          r_state, w_state_next;
    logic [CNT_W-1:0] r_cycles, w_cycles_inc;
    logic [SW-1:0]   r_stall, w_stall_inc;
    logic [PC_W-1:0] r_last_pc;
    logic            r_halted, r_timeout, r_overflow;

    logic            w_start, w_step, w_pc_chg, w_halt, w_tmo, w_push, w_drop_c;
    logic [EW-1:0]   w_din, w_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next state and per-edge events; halt takes priority over timeout.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_step       = 1'b0;
        w_pc_chg     = 1'b0;
        w_halt       = 1'b0;
        w_tmo        = 1'b0;
        w_push       = 1'b0;
        w_din        = '0;
        w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + CNT_W'(1);
        w_stall_inc  = r_stall + SW'(1);
        case (r_state)
            RUN: begin
                w_step   = 1'b1;
                w_pc_chg = (pc != r_last_pc);
                w_push   = w_pc_chg;
                w_din    = {w_cycles_inc, pc};
                w_halt   = !w_pc_chg && (w_stall_inc == SW'(STALL_LIMIT));
                w_tmo    = !w_halt && (MAX_CYCLES != 0) &&
                           (({1'b0, r_cycles} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_CYCLES));
                if (w_halt)     w_state_next = HALTED;
                else if (w_tmo) w_state_next = DONE;
            end
            default: begin
                if (start) begin
                    w_start      = 1'b1;
                    w_push       = 1'b1;
                    w_din        = {CNT_W'(0), pc};
                    w_state_next = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycles   <= '0;
            r_stall    <= '0;
            r_last_pc  <= '0;
            r_halted   <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_cycles   <= '0;
            r_stall    <= '0;
            r_last_pc  <= pc;
            r_halted   <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_step) begin
            r_cycles <= w_cycles_inc;
            if (w_pc_chg) begin
                r_last_pc <= pc;
                r_stall   <= '0;
            end else begin
                r_stall <= w_stall_inc;
            end
            if (w_halt)   r_halted   <= 1'b1;
            if (w_tmo)    r_timeout  <= 1'b1;
            if (w_drop_c) r_overflow <= 1'b1;
        end
    end

    trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_flush  (w_start),
        .i_push   (w_push),
        .i_din    (w_din),
        .i_ready  (trace.trace_ready),
        .o_valid  (trace.trace_valid),
        .o_dout   (w_head),
        .o_drop_c (w_drop_c)
    );

    assign trace.trace_cycle = w_head[EW-1 -: CNT_W];
    assign trace.trace_pc    = w_head[PC_W-1:0];
    assign cycles   = r_cycles;
    assign running  = (r_state == RUN);
    assign halted   = r_halted;
    assign timeout  = r_timeout;
    assign overflow = r_overflow;

`ifdef SNAPSHOT_EN
    logic [NUM_WATCH*32-1:0] r_snap;

    // Captured only on the edge that ends a run; start leaves it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              r_snap <= '0;
        else if (w_halt || w_tmo) r_snap <= watch;
    end
    assign snap_data = r_snap;
`else
    logic w_unused_watch;
    assign w_unused_watch = ^watch;
`endif
endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: hand tables, corner sequences, random run vs a queue-based model.
module tb_pc_trace_monitor;
    import trace_pkg::*;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned NUM_WATCH   = 6;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned MAX_CYCLES  = 20;
    localparam int unsigned STALL_LIMIT = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    start = 1'b0;
    logic [PC_W-1:0]         pc = '0;
    logic [NUM_WATCH*32-1:0] watch = '0;
    logic [CNT_W-1:0]        cycles;
    logic                    running, halted, timeout, overflow;
`ifdef SNAPSHOT_EN
    logic [NUM_WATCH*32-1:0] snap_data;
`endif

    trace_if #(.PC_W(PC_W), .CNT_W(CNT_W)) tif ();

    pc_trace_monitor #(
        .PC_W(PC_W), .NUM_WATCH(NUM_WATCH), .DEPTH(DEPTH), .CNT_W(CNT_W),
        .MAX_CYCLES(MAX_CYCLES), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .watch(watch),
        .trace(tif), .cycles(cycles), .running(running), .halted(halted),
        .timeout(timeout), .overflow(overflow)
`ifdef SNAPSHOT_EN
        , .snap_data(snap_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a run flag, plain counters and a bounded queue of entries.
    bit                      m_run, m_halted, m_timeout, m_overflow;
    int                      m_cycles, m_stall;
    logic [PC_W-1:0]         m_last;
    trace_entry_t            m_q[$];
    logic [NUM_WATCH*32-1:0] m_snap;

    task automatic model_reset();
        m_run = 0; m_halted = 0; m_timeout = 0; m_overflow = 0;
        m_cycles = 0; m_stall = 0; m_last = '0; m_q.delete(); m_snap = '0;
    endtask

    task automatic model_edge();
        trace_entry_t e;
        bit pop;
        int nc;
        pop = (m_q.size() > 0) && tif.trace_ready;
        if (!m_run && start) begin
            m_q.delete();
            m_run = 1; m_halted = 0; m_timeout = 0; m_overflow = 0;
            m_cycles = 0; m_stall = 0; m_last = pc;
            e.cycle = '0; e.pc = pc;
            m_q.push_back(e);
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_run) begin
                nc = (m_cycles + 1 > 65535) ? 65535 : m_cycles + 1;
                if (pc != m_last) begin
                    if (m_q.size() < DEPTH) begin
                        e.cycle = CNT_W'(nc); e.pc = pc;
                        m_q.push_back(e);
                    end else m_overflow = 1;
                    m_last = pc; m_stall = 0;
                end else m_stall++;
                if (m_stall == STALL_LIMIT) begin
                    m_run = 0; m_halted = 1; m_snap = watch;
                end else if (MAX_CYCLES != 0 && m_cycles + 1 == MAX_CYCLES) begin
                    m_run = 0; m_timeout = 1; m_snap = watch;
                end
                m_cycles = nc;
            end
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".running"},  64'(running),  64'(m_run));
        chk({tag, ".halted"},   64'(halted),   64'(m_halted));
        chk({tag, ".timeout"},  64'(timeout),  64'(m_timeout));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_overflow));
        chk({tag, ".cycles"},   64'(cycles),   64'(m_cycles));
        chk({tag, ".valid"},    64'(tif.trace_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk({tag, ".tcycle"}, 64'(tif.trace_cycle), 64'(m_q[0].cycle));
            chk({tag, ".tpc"},    64'(tif.trace_pc),    64'(m_q[0].pc));
        end
`ifdef SNAPSHOT_EN
        chk({tag, ".snap"}, 64'(snap_data[63:0]), 64'(m_snap[63:0]));
`endif
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        cmp_model(tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".running"},  64'(running),  64'(0));
        chk({tag, ".halted"},   64'(halted),   64'(0));
        chk({tag, ".timeout"},  64'(timeout),  64'(0));
        chk({tag, ".overflow"}, 64'(overflow), 64'(0));
        chk({tag, ".cycles"},   64'(cycles),   64'(0));
        chk({tag, ".valid"},    64'(tif.trace_valid), 64'(0));
        chk({tag, ".tcycle"},   64'(tif.trace_cycle), 64'(0));
        chk({tag, ".tpc"},      64'(tif.trace_pc),    64'(0));
    endtask

    typedef struct {
        logic        start;
        logic [31:0] pc;
        logic        ready;
        logic        e_run, e_halt, e_tmo;
        int          e_cyc;
        logic        e_valid;
        int          e_tcyc;
        logic [31:0] e_tpc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // PC 0,4,8,12,16 then stuck: halt four edges after settling, consumer always ready.
        vecs[0] = '{1, 32'd0,  1, 1, 0, 0, 0, 1, 0, 32'd0};
        vecs[1] = '{0, 32'd4,  1, 1, 0, 0, 1, 1, 1, 32'd4};
        vecs[2] = '{0, 32'd8,  1, 1, 0, 0, 2, 1, 2, 32'd8};
        vecs[3] = '{0, 32'd12, 1, 1, 0, 0, 3, 1, 3, 32'd12};
        vecs[4] = '{0, 32'd16, 1, 1, 0, 0, 4, 1, 4, 32'd16};
        vecs[5] = '{0, 32'd16, 1, 1, 0, 0, 5, 0, 0, 32'd0};
        vecs[6] = '{0, 32'd16, 1, 1, 0, 0, 6, 0, 0, 32'd0};
        vecs[7] = '{0, 32'd16, 1, 1, 0, 0, 7, 0, 0, 32'd0};
        vecs[8] = '{0, 32'd16, 1, 0, 1, 0, 8, 0, 0, 32'd0};
        vecs[9] = '{0, 32'd16, 1, 0, 1, 0, 8, 0, 0, 32'd0};

        tif.trace_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start = vecs[i].start; pc = vecs[i].pc; tif.trace_ready = vecs[i].ready;
            step($sformatf("tbl%0d", i));
            start = 1'b0;
            chk($sformatf("tbl%0d.running", i), 64'(running), 64'(vecs[i].e_run));
            chk($sformatf("tbl%0d.halted", i),  64'(halted),  64'(vecs[i].e_halt));
            chk($sformatf("tbl%0d.timeout", i), 64'(timeout), 64'(vecs[i].e_tmo));
            chk($sformatf("tbl%0d.cycles", i),  64'(cycles),  64'(vecs[i].e_cyc));
            chk($sformatf("tbl%0d.valid", i),   64'(tif.trace_valid), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("tbl%0d.tcycle", i), 64'(tif.trace_cycle), 64'(vecs[i].e_tcyc));
                chk($sformatf("tbl%0d.tpc", i),    64'(tif.trace_pc),    64'(vecs[i].e_tpc));
            end
        end

        // Timeout: PC moves every cycle, run ends at cycles == MAX_CYCLES.
        start = 1'b1; pc = 32'h100; tif.trace_ready = 1'b1;
        step("tmo.start");
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            pc = 32'h100 + 32'(4 * i);
            step("tmo.run");
            if (i == 19) chk("tmo.still_running", 64'(running), 64'(1));
        end
        chk("tmo.running", 64'(running), 64'(0));
        chk("tmo.timeout", 64'(timeout), 64'(1));
        chk("tmo.halted",  64'(halted),  64'(0));
        chk("tmo.cycles",  64'(cycles),  64'(20));

        // Overflow: six entries into a four-deep FIFO with the consumer stalled.
        tif.trace_ready = 1'b0; start = 1'b1; pc = 32'h200;
        step("ovf.start");
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            pc = 32'h200 + 32'(4 * i);
            step("ovf.fill");
        end
        chk("ovf.overflow", 64'(overflow), 64'(1));
        tif.trace_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ovf.head%0d.cycle", j), 64'(tif.trace_cycle), 64'(j));
            chk($sformatf("ovf.head%0d.pc", j),    64'(tif.trace_pc),    64'(32'h200 + 32'(4 * j)));
            step("ovf.drain");
        end
        chk("ovf.empty", 64'(tif.trace_valid), 64'(0));

        // Full FIFO with a pop and a push on the same edge: nothing dropped.
        tif.trace_ready = 1'b0; start = 1'b1; pc = 32'h300;
        step("full.start");
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            pc = 32'h300 + 32'(4 * i);
            step("full.fill");
        end
        tif.trace_ready = 1'b1; pc = 32'h310;
        step("full.popush");
        chk("full.overflow", 64'(overflow), 64'(0));
        chk("full.head.cycle", 64'(tif.trace_cycle), 64'(1));
        chk("full.head.pc",    64'(tif.trace_pc),    64'(32'h304));
        for (int i = 0; i < 6; i++) step("full.drain");

        // Asynchronous reset between edges during a run.
        tif.trace_ready = 1'b0; start = 1'b1; pc = 32'h500;
        step("arst.start");
        start = 1'b0; pc = 32'h504;
        step("arst.run");
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("arst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step("arst.idle");

`ifdef SNAPSHOT_EN
        // Snapshot taken at halt and kept across a new start.
        watch = '0; watch[31:0] = 32'hDEAD; tif.trace_ready = 1'b1;
        start = 1'b1; pc = 32'h400;
        step("snap.start");
        start = 1'b0;
        for (int i = 0; i < 4; i++) step("snap.stall");
        chk("snap.halted", 64'(halted), 64'(1));
        chk("snap.word0", 64'(snap_data[31:0]), 64'(32'hDEAD));
        watch[31:0] = 32'h1234; start = 1'b1;
        step("snap.restart");
        start = 1'b0;
        chk("snap.held", 64'(snap_data[31:0]), 64'(32'hDEAD));
`endif

        // Random run against the model.
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 2) != 0) pc = 32'($urandom_range(0, 3)) << 2;
            tif.trace_ready = 1'($urandom_range(0, 1));
            for (int w = 0; w < int'(NUM_WATCH); w++) watch[32*w +: 32] = $urandom;
            step("rnd");
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
